// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks of CW bits.
// Each stage ripples one chunk and forwards its carry, the finished sum chunks and the pending operand chunks.
module pipelined_rca #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             out_valid
);
    localparam int CW = WIDTH / STAGES;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // inputs of the last stage, which feeds the output registers directly
    logic [CW-1:0]    f_a;
    logic [CW-1:0]    f_b;
    logic             f_c;
    logic             f_v;
    logic [CW:0]      f_r;
    logic [WIDTH-1:0] f_sum;
    logic             f_c_msb;

    // subtract is a + ~b + 1, so c_in is forced high and ignored
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | c_in;

    if (STAGES == 1) begin : g_single
        assign f_a   = a;
        assign f_b   = b_eff;
        assign f_c   = cin_eff;
        assign f_v   = in_valid;
        assign f_sum = f_r[CW-1:0];
    end else begin : g_pipe
        for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
            localparam int RW = WIDTH - k * CW;

            logic [RW-1:0]        i_a;
            logic [RW-1:0]        i_b;
            logic                 i_c;
            logic                 i_v;
            logic [CW:0]          r;
            logic [RW-CW-1:0]     q_a;
            logic [RW-CW-1:0]     q_b;
            logic [(k+1)*CW-1:0]  q_s;
            logic                 q_c;
            logic                 q_v;

            if (k == 0) begin : g_in
                assign i_a = a;
                assign i_b = b_eff;
                assign i_c = cin_eff;
                assign i_v = in_valid;
            end else begin : g_in
                assign i_a = g_stage[k-1].q_a;
                assign i_b = g_stage[k-1].q_b;
                assign i_c = g_stage[k-1].q_c;
                assign i_v = g_stage[k-1].q_v;
            end

            assign r = {1'b0, i_a[CW-1:0]} + {1'b0, i_b[CW-1:0]} + {{CW{1'b0}}, i_c};

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q_v <= 1'b0;
                end else if (en) begin
                    q_v <= i_v;
                    q_c <= r[CW];
                    q_a <= i_a[RW-1:CW];
                    q_b <= i_b[RW-1:CW];
                end
            end

            // finished sum chunks accumulate from the bottom up
            if (k == 0) begin : g_sum
                always_ff @(posedge clk) begin
                    if (rst_n && en) begin
                        q_s <= r[CW-1:0];
                    end
                end
            end else begin : g_sum
                always_ff @(posedge clk) begin
                    if (rst_n && en) begin
                        q_s <= {r[CW-1:0], g_stage[k-1].q_s};
                    end
                end
            end
        end

        assign f_a   = g_stage[STAGES-2].q_a;
        assign f_b   = g_stage[STAGES-2].q_b;
        assign f_c   = g_stage[STAGES-2].q_c;
        assign f_v   = g_stage[STAGES-2].q_v;
        assign f_sum = {f_r[CW-1:0], g_stage[STAGES-2].q_s};
    end

    assign f_r = {1'b0, f_a} + {1'b0, f_b} + {{CW{1'b0}}, f_c};

    // carry into the MSB recovered from the MSB sum bit: c = s ^ a ^ b
    assign f_c_msb = f_a[CW-1] ^ f_b[CW-1] ^ f_r[CW-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s         <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= f_v;
            if (f_v) begin
                s     <= f_sum;
                c_out <= f_r[CW];
                ovf   <= f_c_msb ^ f_r[CW];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed bench for pipelined_rca: a 4-bit single-stage instance and a 16-bit four-stage instance.
module tb_pipelined_rca;
    logic clk = 1'b0;
    logic rst_n;

    logic       en4, iv4, cin4, sub4;
    logic [3:0] a4, b4, s4;
    logic       c4, o4, v4;

    logic        en16, iv16, cin16, sub16;
    logic [15:0] a16, b16, s16;
    logic        c16, o16, v16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_rca #(.WIDTH(4), .STAGES(1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .in_valid(iv4),
        .a(a4), .b(b4), .c_in(cin4), .sub(sub4),
        .s(s4), .c_out(c4), .ovf(o4), .out_valid(v4)
    );

    pipelined_rca #(.WIDTH(16), .STAGES(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .en(en16), .in_valid(iv16),
        .a(a16), .b(b16), .c_in(cin16), .sub(sub16),
        .s(s16), .c_out(c16), .ovf(o16), .out_valid(v16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op4(input logic v, input logic [3:0] x, input logic [3:0] y, input logic ci);
        iv4 = v; a4 = x; b4 = y; cin4 = ci; sub4 = 1'b0;
    endtask

    task automatic op16(input logic v, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic sb);
        iv16 = v; a16 = x; b16 = y; cin16 = ci; sub16 = sb;
    endtask

    task automatic exp4(input string tag, input logic v, input logic [3:0] sx, input logic cx);
        chk({tag, ".valid"}, 32'(v4), 32'(v));
        chk({tag, ".s"},     32'(s4), 32'(sx));
        chk({tag, ".c_out"}, 32'(c4), 32'(cx));
    endtask

    task automatic exp16(input string tag, input logic v, input logic [15:0] sx,
                         input logic cx, input logic ox);
        chk({tag, ".valid"}, 32'(v16), 32'(v));
        chk({tag, ".s"},     32'(s16), 32'(sx));
        chk({tag, ".c_out"}, 32'(c16), 32'(cx));
        chk({tag, ".ovf"},   32'(o16), 32'(ox));
    endtask

    initial begin
        rst_n = 1'b0;
        en4 = 1'b1;  op4(1'b0, 4'd0, 4'd0, 1'b0);
        en16 = 1'b1; op16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        exp4("rst_w4", 1'b0, 4'd0, 1'b0);
        chk("rst_w4.ovf", 32'(o4), 32'd0);
        exp16("rst_w16", 1'b0, 16'h0, 1'b0, 1'b0);

        // 4-bit single-stage adds, one edge latency, first sample right after reset
        rst_n = 1'b1;
        op4(1'b1, 4'd4, 4'd4, 1'b1);   tick(); exp4("w4_op1", 1'b1, 4'd9,  1'b0);
        op4(1'b1, 4'd4, 4'd12, 1'b1);  tick(); exp4("w4_op2", 1'b1, 4'd1,  1'b1);
        op4(1'b1, 4'd11, 4'd6, 1'b0);  tick(); exp4("w4_op3", 1'b1, 4'd1,  1'b1);
        op4(1'b1, 4'd5, 4'd4, 1'b1);   tick(); exp4("w4_op4", 1'b1, 4'd10, 1'b0);
        op4(1'b0, 4'd15, 4'd15, 1'b1); tick(); exp4("w4_hold", 1'b0, 4'd10, 1'b0);

        // back-to-back adds with cross-chunk carries
        op16(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0); tick();
        op16(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0); tick();
        op16(1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b0); tick();
        exp16("b2b_fill", 1'b0, 16'h0, 1'b0, 1'b0);
        tick(); exp16("b2b_r1", 1'b1, 16'h0100, 1'b0, 1'b0);
        tick(); exp16("b2b_r2", 1'b1, 16'h0000, 1'b1, 1'b0);
        tick(); exp16("b2b_end", 1'b0, 16'h0000, 1'b1, 1'b0);

        // subtract, signed overflow both ways
        op16(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1); tick();
        op16(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1); tick();
        op16(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0); tick();
        op16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick(); exp16("sub_5m7",    1'b1, 16'hFFFE, 1'b0, 1'b0);
        tick(); exp16("sub_8000m1", 1'b1, 16'h7FFF, 1'b1, 1'b1);
        tick(); exp16("add_7fffp1", 1'b1, 16'h8000, 1'b0, 1'b1);
        tick(); exp16("ovf_end",    1'b0, 16'h8000, 1'b0, 1'b1);

        // stall of three cycles mid-flight; inputs offered during the stall are ignored
        op16(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0); tick();
        op16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0); tick();
        en16 = 1'b0;
        op16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        tick(); exp16("stall_1", 1'b0, 16'h8000, 1'b0, 1'b1);
        tick(); exp16("stall_2", 1'b0, 16'h8000, 1'b0, 1'b1);
        tick(); exp16("stall_3", 1'b0, 16'h8000, 1'b0, 1'b1);
        en16 = 1'b1;
        op16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick(); exp16("stall_late", 1'b0, 16'h8000, 1'b0, 1'b1);
        tick(); exp16("stall_res",  1'b1, 16'h2345, 1'b0, 1'b0);
        en16 = 1'b0;
        tick(); exp16("stall_hold", 1'b1, 16'h2345, 1'b0, 1'b0);
        en16 = 1'b1;
        tick(); exp16("stall_drop", 1'b0, 16'h2345, 1'b0, 1'b0);

        // bubbles: in_valid 1,0,1
        op16(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0); tick();
        op16(1'b0, 16'h7777, 16'h7777, 1'b0, 1'b0); tick();
        op16(1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0); tick();
        op16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick(); exp16("bub_r1",  1'b1, 16'h0030, 1'b0, 1'b0);
        tick(); exp16("bub_gap", 1'b0, 16'h0030, 1'b0, 1'b0);
        tick(); exp16("bub_r2",  1'b1, 16'h0300, 1'b0, 1'b0);
        tick(); exp16("bub_end", 1'b0, 16'h0300, 1'b0, 1'b0);

        // reset with three operations in flight, reset also overriding en = 0
        op16(1'b1, 16'h1111, 16'h1111, 1'b0, 1'b0); tick();
        op16(1'b1, 16'h2222, 16'h2222, 1'b0, 1'b0); tick();
        op16(1'b1, 16'h3333, 16'h3333, 1'b0, 1'b0); tick();
        op16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        en16  = 1'b0;
        tick(); exp16("flush_rst", 1'b0, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        en16  = 1'b1;
        tick(); exp16("flush_1", 1'b0, 16'h0000, 1'b0, 1'b0);
        tick(); exp16("flush_2", 1'b0, 16'h0000, 1'b0, 1'b0);
        tick(); exp16("flush_3", 1'b0, 16'h0000, 1'b0, 1'b0);
        op16(1'b1, 16'h0042, 16'h0001, 1'b0, 1'b0); tick();
        op16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick(); exp16("post_1", 1'b0, 16'h0000, 1'b0, 1'b0);
        tick(); exp16("post_2", 1'b0, 16'h0000, 1'b0, 1'b0);
        tick(); exp16("post_res", 1'b1, 16'h0043, 1'b0, 1'b0);
        tick(); exp16("post_end", 1'b0, 16'h0043, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_rca.md
# pipelined_rca

Parametrised, pipelined ripple-carry adder/subtractor, the successor to the fixed 4-bit combinational RCA. Splits a WIDTH-bit add into STAGES equal chunks, one chunk per clock stage, with carries and pending operand bits carried forward in pipeline registers. Accepts one operation per enabled cycle. Supports add/subtract mode, signed-overflow detection, valid tagging and a global stall. It serves as the arithmetic datapath for the multi-cycle ALU experiments.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES; STAGES ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  global enable; 0 freezes the entire pipeline, including valid bits.
- in_valid  in  1  a, b, c_in, sub carry a new operation this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in, used in add mode only.
- sub  in  1  0 = add, 1 = subtract.
- s  out  WIDTH  result sum/difference, registered.
- c_out  out  1  carry out of bit WIDTH-1; in subtract mode, 1 = no borrow.
- ovf  out  1  signed overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- out_valid  out  1  s, c_out and ovf hold a completed operation.

## Operation
- Effective operands:
  - Add: B' = b, cin' = c_in.
  - Subtract: B' = ~b, cin' = 1, and c_in is ignored.
- Stage 0 combinationally adds chunk 0 (bits CW-1:0) of a and B' with cin'. It registers the chunk-0 sum, its carry, upper operand chunks 1..STAGES-1 of a and B', and the valid bit.
- Stage k (1..STAGES-1) adds chunk k of the delayed operands using the stage k-1 carry. It registers the chunk-k sum, passes forward all previously computed sum chunks and the remaining operand chunks, and propagates the valid bit.
- The last stage also captures the carry into bit WIDTH-1 to form ovf.
- Data-path registers load on every enabled edge whether or not valid is set. Bubbles carry don't-care data with valid = 0.
- Output registers s, c_out, ovf load only when the final-stage valid bit is 1. Otherwise they hold their previous values.
- out_valid = final-stage valid bit; it is a one-cycle pulse per operation unless en = 0 holds it.
- en = 0: no register changes, valid bits included. Outputs and out_valid hold steady.
- Reset (rst_n = 0 at an edge):
  - All valid bits, s, c_out and ovf clear to 0.
  - Reset has priority over en.
  - Operations in flight are discarded and never emerge.
- in_valid = 0 with en = 1 inserts a bubble. Operand values are don't-care.
- Back-to-back operations are supported at full rate: one result per enabled cycle after fill.
- STAGES = 1 degenerates to a single registered full-width adder.

## Timing
- Reset values: s = 0, c_out = 0, ovf = 0, out_valid = 0.
- Latency: an operation sampled at enabled edge t appears on the outputs, with out_valid = 1, immediately after the STAGES-th enabled edge counting t as the first.
  - Example: STAGES = 4, no stalls → valid after edge t+3.
- Each en = 0 cycle adds exactly one cycle of latency to every in-flight operation.
- Throughput: 1 operation per enabled cycle; order is preserved.
- The critical path is one CW-bit ripple plus the mode XOR, in stage 0 only.
- rst_n deasserted at edge r: the first operation may be sampled at edge r+1 (the first edge with rst_n = 1).

## Test plan
- WIDTH = 4, STAGES = 1, add mode, sequence (a, b, c_in) = (4, 4, 1), (4, 12, 1), (11, 6, 0), (5, 4, 1). Required results:
  - s = 9, c_out = 0
  - s = 1, c_out = 1
  - s = 1, c_out = 1
  - s = 10, c_out = 0
  - Each result appears one edge after its operation is sampled.
- WIDTH = 16, STAGES = 4, back-to-back adds 0x00FF+0x0001+0 then 0xFFFF+0x0001+0 → s = 0x0100, c_out = 0, then s = 0x0000, c_out = 1, on consecutive cycles. Cross-chunk carry must be correct.
- Subtract checks at WIDTH = 16, STAGES = 4:
  - 0x0005 − 0x0007 → s = 0xFFFE, c_out = 0, ovf = 0.
  - 0x8000 − 0x0001 → s = 0x7FFF, c_out = 1, ovf = 1.
  - 0x7FFF + 0x0001 (add) → s = 0x8000, ovf = 1.
- Stall: issue 0x1234+0x1111, then hold en = 0 for 3 cycles mid-flight → s = 0x2345 arrives exactly 3 cycles late. Outputs and out_valid stay frozen during the stall.
- Bubbles: in_valid pattern 1,0,1 → out_valid pattern 1,0,1. s holds the first result through the bubble cycle.
- Reset mid-flight: 3 operations in the pipe, then rst_n = 0 for one edge → outputs 0, out_valid 0. None of the flushed operations appear afterwards, and a new operation completes with normal latency.
